// File: rtl/synth_cfg_pkg.sv
// synth_cfg_pkg: constants, field widths and types shared by the config loader and digital_synthesizer_v1.
package synth_cfg_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int FRAME_LEN = 15;
    localparam int F_W = 32, TI_W = 10, TP_W = 13, NUM_W = 5, DEV_W = 22;
    localparam logic [1:0] ERR_NONE = 2'd0, ERR_CHECKSUM = 2'd1, ERR_TIMEOUT = 2'd2, ERR_RANGE = 2'd3;
    localparam logic [1:0] SIG_LFM = 2'd1, SIG_PSK = 2'd2, SIG_NOISE = 2'd3;
    typedef enum logic [1:0] {HUNT, RECV, CHECK, COMMIT} state_t;
    typedef struct packed {
        logic [1:0]       sig_type;
        logic             start;
        logic             stop;
        logic [F_W-1:0]   f_carrier;
        logic [TI_W-1:0]  t_impulse;
        logic [TP_W-1:0]  t_period;
        logic [NUM_W-1:0] num_imp;
        logic [DEV_W-1:0] deviation;
    } cfg_t;
    function automatic logic valid_type(input logic [1:0] t);
        return t == SIG_LFM || t == SIG_PSK || t == SIG_NOISE;
    endfunction
endpackage

// File: rtl/cfg_frame_rx.sv
// cfg_frame_rx: byte assembly into the shadow config, running XOR checksum and inter-byte timeout.
module cfg_frame_rx
    import synth_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       accept,
    input  logic       recv,
    output cfg_t       shadow,
    output logic [7:0] acc,
    output logic       sync_hit,
    output logic       last_byte,
    output logic       timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [3:0]    idx;
    logic [TW-1:0] tmr;
    assign sync_hit  = accept && !recv && data == SYNC_BYTE;
    assign last_byte = accept && recv && idx == 4'(FRAME_LEN - 1);
    assign timeout   = recv && !accept && tmr == TW'(TIMEOUT_CYCLES);
    // Seeding the accumulator with the sync byte makes a good frame XOR to zero after b14.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            tmr    <= '0;
            acc    <= '0;
            shadow <= '0;
        end else if (sync_hit) begin
            idx <= 4'd1;
            tmr <= '0;
            acc <= SYNC_BYTE;
        end else if (accept && recv) begin
            idx <= idx + 4'd1;
            tmr <= '0;
            acc <= acc ^ data;
            case (idx)
                4'd1:  {shadow.stop, shadow.start, shadow.sig_type} <= data[3:0];
                4'd2:  shadow.f_carrier[7:0]   <= data;
                4'd3:  shadow.f_carrier[15:8]  <= data;
                4'd4:  shadow.f_carrier[23:16] <= data;
                4'd5:  shadow.f_carrier[31:24] <= data;
                4'd6:  shadow.t_impulse[7:0]   <= data;
                4'd7:  shadow.t_impulse[9:8]   <= data[1:0];
                4'd8:  shadow.t_period[7:0]    <= data;
                4'd9:  shadow.t_period[12:8]   <= data[4:0];
                4'd10: shadow.num_imp          <= data[4:0];
                4'd11: shadow.deviation[7:0]   <= data;
                4'd12: shadow.deviation[15:8]  <= data;
                4'd13: shadow.deviation[21:16] <= data[5:0];
                default: ;
            endcase
        end else if (recv) begin
            tmr <= tmr + 1'b1;
        end
    end
endmodule

// File: rtl/synth_config_loader.sv
// synth_config_loader: validates 15-byte config frames and commits them atomically to the synthesizer.
// Define CFG_RANGE_CHECK_EN to also reject frames whose fields fall outside the legal range.
module synth_config_loader
    import synth_cfg_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 100_000,
    parameter logic [31:0] F_MIN = 32'd1_200_000_000,
    parameter logic [31:0] F_MAX = 32'd4_000_000_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              SIGN_START_GEN,
    output logic [1:0]        SIGNAL_TYPE,
    output logic [F_W-1:0]    F_CARRIER,
    output logic [TI_W-1:0]   T_IMPULSE,
    output logic [TP_W-1:0]   T_PERIOD,
    output logic [NUM_W-1:0]  NUM_OF_IMP,
    output logic [DEV_W-1:0]  DEVIATION,
    output logic              CFG_UPDATE,
    output logic              FRAME_ERR,
    output logic [1:0]        ERR_CODE,
    output logic [7:0]        ERR_COUNT
);
    state_t     state, state_n;
    cfg_t       shadow;
    logic [7:0] acc;
    logic       accept, sync_hit, last_byte, timeout, range_ok, err_evt;
    logic [1:0] err_n;
    assign IN_READY = state == HUNT || state == RECV;
    assign accept   = IN_VALID && IN_READY;
    cfg_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk(CLK), .rst(RESET), .data(IN_DATA), .accept(accept), .recv(state == RECV),
        .shadow(shadow), .acc(acc), .sync_hit(sync_hit), .last_byte(last_byte), .timeout(timeout)
    );
`ifdef CFG_RANGE_CHECK_EN
    assign range_ok = shadow.f_carrier >= F_MIN && shadow.f_carrier <= F_MAX && shadow.t_impulse != '0
                      && shadow.t_period > {3'd0, shadow.t_impulse} && valid_type(shadow.sig_type);
`else
    logic unused_range;
    assign range_ok     = 1'b1;
    assign unused_range = ^{F_MIN, F_MAX};
`endif
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= HUNT;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        err_evt = 1'b0;
        err_n   = ERR_NONE;
        case (state)
            HUNT: state_n = sync_hit ? RECV : HUNT;
            RECV: begin
                err_evt = timeout;
                err_n   = ERR_TIMEOUT;
                state_n = timeout ? HUNT : last_byte ? CHECK : RECV;
            end
            CHECK: begin
                err_evt = acc != 8'h00 || !range_ok;
                err_n   = acc != 8'h00 ? ERR_CHECKSUM : ERR_RANGE;
                state_n = err_evt ? HUNT : COMMIT;
            end
            default: state_n = HUNT;
        endcase
    end
    // Outputs move only on the COMMIT edge, so rejected or partial frames leave them untouched.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SIGN_START_GEN <= 1'b0;
            SIGNAL_TYPE    <= '0;
            F_CARRIER      <= '0;
            T_IMPULSE      <= '0;
            T_PERIOD       <= '0;
            NUM_OF_IMP     <= '0;
            DEVIATION      <= '0;
            CFG_UPDATE     <= 1'b0;
            FRAME_ERR      <= 1'b0;
            ERR_CODE       <= ERR_NONE;
            ERR_COUNT      <= '0;
        end else begin
            CFG_UPDATE <= state == COMMIT;
            FRAME_ERR  <= err_evt;
            if (err_evt) begin
                ERR_CODE  <= err_n;
                ERR_COUNT <= ERR_COUNT + {7'd0, ERR_COUNT != 8'hFF};
            end
            if (state == COMMIT) begin
                SIGN_START_GEN <= shadow.stop ? 1'b0 : shadow.start | SIGN_START_GEN;
                SIGNAL_TYPE    <= shadow.sig_type;
                F_CARRIER      <= shadow.f_carrier;
                T_IMPULSE      <= shadow.t_impulse;
                T_PERIOD       <= shadow.t_period;
                NUM_OF_IMP     <= shadow.num_imp;
                DEVIATION      <= shadow.deviation;
            end
        end
    end
endmodule
